// File: rtl/serial_link_pkg.sv
// Shared FSM states and width helper for serial_link.
// SERIAL_LINK_PARITY_EN adds the PARITY state to both FSMs.
package serial_link_pkg;

`ifdef SERIAL_LINK_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } link_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } link_state_t;
`endif

  // Never returns zero so every counter keeps at least one bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_link_fifo.sv
// Power-of-two FIFO with combinational head; push on full
// is accepted only alongside a pop.
module serial_link_fifo
  import serial_link_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic              full
);

  localparam int AW = clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = FIFO_DEPTH[AW:0];
  localparam logic [AW:0] CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop) rptr <= rptr + PTR_ONE;
      unique case (1'b1)
        do_push && !do_pop: count <= count + CNT_ONE;
        do_pop && !do_push: count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/serial_link.sv
// Buffered UART: RX/TX FSMs, each side behind a FIFO.
// Define SERIAL_LINK_PARITY_EN for an even-parity bit and parity_err.
module serial_link
  import serial_link_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              UART_RX,
  output logic              UART_TX,
  input  logic [DATA_W-1:0] in,
  input  logic              send_flag,
  input  logic              receive_flag,
  output logic [DATA_W-1:0] out,
  output logic              data_available,
  output logic              tx_full,
  output logic              rx_overrun,
  output logic              frame_err
`ifdef SERIAL_LINK_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = clog2(DIV);
  localparam int BW  = clog2(DATA_W);
  localparam logic [CW-1:0] CNT_END = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_MID = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam logic [BW-1:0] BIT_END = BW'(DATA_W - 1);
  localparam logic [BW-1:0] BIT_ONE = 1;

  logic              rx_s1;
  logic              rx_s2;
  logic              rf_q;
  logic              sf_q;
  logic              rf_rise;
  logic              sf_rise;
  link_state_t       rx_st;
  link_state_t       tx_st;
  logic [CW-1:0]     rx_cnt;
  logic [CW-1:0]     tx_cnt;
  logic [BW-1:0]     rx_bit;
  logic [BW-1:0]     tx_bit;
  logic [DATA_W-1:0] rx_sh;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] rx_head;
  logic [DATA_W-1:0] tx_head;
  logic              rx_push;
  logic              rx_pop;
  logic              tx_pop;
  logic              rx_empty;
  logic              rx_full;
  logic              tx_empty;
  logic              tx_line;
  logic              rx_ok;
`ifdef SERIAL_LINK_PARITY_EN
  logic              rx_par_bad;
  logic              tx_par;

  assign rx_ok = rx_s2 && !rx_par_bad;
`else
  assign rx_ok = rx_s2;
`endif

  assign rf_rise        = receive_flag && !rf_q;
  assign sf_rise        = send_flag && !sf_q;
  assign rx_pop         = rf_rise && !rx_empty;
  assign out            = receive_flag ? hold : '0;
  assign data_available = !rx_empty;
  assign UART_TX        = tx_line;

  // Next frame loads straight out of STOP so frames run back to back.
  assign tx_pop = !tx_empty && (tx_st == ST_IDLE ||
                  (tx_st == ST_STOP && tx_cnt == CNT_END));

  always_ff @(posedge CLOCK_50) begin
    rf_q <= receive_flag;
    sf_q <= send_flag;
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      hold  <= '0;
    end else begin
      rx_s1 <= UART_RX;
      rx_s2 <= rx_s1;
      if (rx_pop) hold <= rx_head;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      rx_st      <= ST_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_sh      <= '0;
      rx_push    <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
`ifdef SERIAL_LINK_PARITY_EN
      rx_par_bad <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_push <= 1'b0;
      if (rf_rise) begin
        rx_overrun <= 1'b0;
        frame_err  <= 1'b0;
`ifdef SERIAL_LINK_PARITY_EN
        parity_err <= 1'b0;
`endif
      end
      if (rx_push && rx_full && !rx_pop) rx_overrun <= 1'b1;
      unique case (rx_st)
        ST_IDLE: begin
          if (!rx_s2) begin
            rx_st  <= ST_START;
            rx_cnt <= '0;
          end
        end
        ST_START: begin
          if (rx_cnt == CNT_MID) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_st  <= rx_s2 ? ST_IDLE : ST_DATA;
`ifdef SERIAL_LINK_PARITY_EN
            rx_par_bad <= 1'b0;
`endif
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (rx_cnt == CNT_END) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[DATA_W-1:1]};
            rx_bit <= rx_bit + BIT_ONE;
            if (rx_bit == BIT_END) begin
`ifdef SERIAL_LINK_PARITY_EN
              rx_st <= ST_PARITY;
`else
              rx_st <= ST_STOP;
`endif
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
`ifdef SERIAL_LINK_PARITY_EN
        ST_PARITY: begin
          if (rx_cnt == CNT_END) begin
            rx_cnt <= '0;
            rx_st  <= ST_STOP;
            if (rx_s2 != ^rx_sh) begin
              rx_par_bad <= 1'b1;
              parity_err <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
`endif
        ST_STOP: begin
          if (rx_cnt == CNT_END) begin
            rx_cnt <= '0;
            rx_st  <= ST_IDLE;
            if (rx_ok) rx_push <= 1'b1;
            if (!rx_s2) frame_err <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        default: rx_st <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      tx_st   <= ST_IDLE;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '0;
      tx_line <= 1'b1;
`ifdef SERIAL_LINK_PARITY_EN
      tx_par  <= 1'b0;
`endif
    end else if (tx_pop) begin
      tx_st   <= ST_START;
      tx_cnt  <= '0;
      tx_sh   <= tx_head;
      tx_line <= 1'b0;
`ifdef SERIAL_LINK_PARITY_EN
      tx_par  <= ^tx_head;
`endif
    end else begin
      unique case (tx_st)
        ST_IDLE: tx_line <= 1'b1;
        ST_START: begin
          if (tx_cnt == CNT_END) begin
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_st   <= ST_DATA;
            tx_line <= tx_sh[0];
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (tx_cnt == CNT_END) begin
            tx_cnt <= '0;
            tx_bit <= tx_bit + BIT_ONE;
            tx_sh  <= tx_sh >> 1;
            if (tx_bit == BIT_END) begin
`ifdef SERIAL_LINK_PARITY_EN
              tx_st   <= ST_PARITY;
              tx_line <= tx_par;
`else
              tx_st   <= ST_STOP;
              tx_line <= 1'b1;
`endif
            end else begin
              tx_line <= tx_sh[1];
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
`ifdef SERIAL_LINK_PARITY_EN
        ST_PARITY: begin
          if (tx_cnt == CNT_END) begin
            tx_cnt  <= '0;
            tx_st   <= ST_STOP;
            tx_line <= 1'b1;
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
`endif
        ST_STOP: begin
          if (tx_cnt == CNT_END) begin
            tx_cnt <= '0;
            tx_st  <= ST_IDLE;
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        default: tx_st <= ST_IDLE;
      endcase
    end
  end

  serial_link_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_rx_fifo (
    .clk  (CLOCK_50),
    .reset(reset),
    .push (rx_push),
    .wdata(rx_sh),
    .pop  (rx_pop),
    .rdata(rx_head),
    .empty(rx_empty),
    .full (rx_full)
  );

  serial_link_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk  (CLOCK_50),
    .reset(reset),
    .push (sf_rise),
    .wdata(in),
    .pop  (tx_pop),
    .rdata(tx_head),
    .empty(tx_empty),
    .full (tx_full)
  );

endmodule

// File: tb/tb_serial_link.sv
// Directed bench for serial_link at DIV=10, DATA_W=8, FIFO_DEPTH=4.
// Honours SERIAL_LINK_PARITY_EN for frame layout and parity_err.
module tb_serial_link;

  localparam int DIV = 10;
`ifdef SERIAL_LINK_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       UART_RX;
  logic       UART_TX;
  logic [7:0] in;
  logic       send_flag;
  logic       receive_flag;
  logic [7:0] out;
  logic       data_available;
  logic       tx_full;
  logic       rx_overrun;
  logic       frame_err;
`ifdef SERIAL_LINK_PARITY_EN
  logic       parity_err;
`endif

  serial_link #(
    .DATA_W    (8),
    .CLK_HZ    (1000000),
    .BAUD      (100000),
    .FIFO_DEPTH(4)
  ) dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .UART_RX       (UART_RX),
    .UART_TX       (UART_TX),
    .in            (in),
    .send_flag     (send_flag),
    .receive_flag  (receive_flag),
    .out           (out),
    .data_available(data_available),
    .tx_full       (tx_full),
    .rx_overrun    (rx_overrun),
    .frame_err     (frame_err)
`ifdef SERIAL_LINK_PARITY_EN
    ,
    .parity_err    (parity_err)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    bit         is_tx;
    logic [7:0] d;
    logic       stop;
    logic       avail;
    logic       ferr;
  } vec_t;

  vec_t       tbl [7];
  logic [7:0] pat [6];
  logic [7:0] v;
  logic [7:0] last;
  int         gap;
  int         lows;
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [FB-1:0] frame_bits(input logic [7:0] d);
    logic [FB-1:0] b;
    b      = '1;
    b[0]   = 1'b0;
    b[8:1] = d;
`ifdef SERIAL_LINK_PARITY_EN
    b[9]   = ^d;
`endif
    return b;
  endfunction

  task automatic rx_frame(input logic [7:0] d, input logic stop);
    logic [FB-1:0] b;
    b = frame_bits(d);
    b[FB-1] = stop;
    for (int i = 0; i < FB; i++) begin
      UART_RX = b[i];
      repeat (DIV) @(negedge CLOCK_50);
    end
    UART_RX = 1'b1;
  endtask

  task automatic send(input logic [7:0] d);
    in = d;
    send_flag = 1'b1;
    @(negedge CLOCK_50);
    send_flag = 1'b0;
    @(negedge CLOCK_50);
  endtask

  task automatic rd(output logic [7:0] r);
    receive_flag = 1'b1;
    @(negedge CLOCK_50);
    r = out;
    receive_flag = 1'b0;
    @(negedge CLOCK_50);
  endtask

  // Waits (bounded) for a start bit, then checks every cycle of the frame.
  task automatic cap_frame(input logic [7:0] d, output int g);
    logic [FB-1:0] b;
    int bad;
    b = frame_bits(d);
    g = 0;
    while (UART_TX !== 1'b0 && g < 400) begin
      @(negedge CLOCK_50);
      g++;
    end
    bad = 0;
    for (int i = 0; i < FB * DIV; i++) begin
      if (UART_TX !== b[i / DIV]) bad++;
      @(negedge CLOCK_50);
    end
    chk($sformatf("tx_frame_%h bit_errors", d), bad, 0);
  endtask

  task automatic idle_low(input int n, output int l);
    l = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge CLOCK_50);
      if (UART_TX !== 1'b1) l++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h3C, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 8'h5A, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    pat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    last = 8'h00;

    reset = 1'b0;
    UART_RX = 1'b1;
    in = 8'h00;
    send_flag = 1'b0;
    receive_flag = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    chk("reset UART_TX", UART_TX, 1);
    chk("reset out", out, 0);
    chk("reset data_available", data_available, 0);
    chk("reset tx_full", tx_full, 0);
    chk("reset rx_overrun", rx_overrun, 0);
    chk("reset frame_err", frame_err, 0);
    reset = 1'b1;
    @(negedge CLOCK_50);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].is_tx) begin
        send(tbl[i].d);
        cap_frame(tbl[i].d, gap);
        chk($sformatf("tx_latency[%0d]", i), gap, 0);
        idle_low(20, lows);
        chk($sformatf("tx_idle_after[%0d]", i), lows, 0);
      end else begin
        rx_frame(tbl[i].d, tbl[i].stop);
        repeat (20) @(negedge CLOCK_50);
        chk($sformatf("rx_avail[%0d]", i), data_available, tbl[i].avail);
        chk($sformatf("rx_frame_err[%0d]", i), frame_err, tbl[i].ferr);
        if (tbl[i].avail) last = tbl[i].d;
        rd(v);
        chk($sformatf("rx_out[%0d]", i), v, last);
        chk($sformatf("rx_out_low[%0d]", i), out, 0);
        chk($sformatf("rx_avail_after[%0d]", i), data_available, 0);
        chk($sformatf("rx_ferr_clear[%0d]", i), frame_err, 0);
      end
    end

    // 4-cycle low pulse on an idle line must not start a frame
    UART_RX = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    UART_RX = 1'b1;
    repeat (150) @(negedge CLOCK_50);
    chk("glitch data_available", data_available, 0);
    chk("glitch frame_err", frame_err, 0);

    // five frames into a four-entry FIFO
    for (int k = 0; k < 5; k++) rx_frame(pat[k], 1'b1);
    repeat (20) @(negedge CLOCK_50);
    chk("ovr rx_overrun", rx_overrun, 1);
    chk("ovr data_available", data_available, 1);
    for (int k = 0; k < 4; k++) begin
      rd(v);
      chk($sformatf("ovr out[%0d]", k), v, pat[k]);
    end
    chk("ovr drained", data_available, 0);
    chk("ovr cleared", rx_overrun, 0);

    // six back-to-back send edges: one popped, four queued, one dropped
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          send(pat[k]);
          if (k == 3) chk("b2b tx_full after 4", tx_full, 0);
        end
        chk("b2b tx_full after 6", tx_full, 1);
      end
      begin
        for (int k = 0; k < 5; k++) begin
          cap_frame(pat[k], gap);
          if (k > 0) chk($sformatf("b2b gap[%0d]", k), gap, 0);
        end
      end
    join
    idle_low(200, lows);
    chk("b2b no sixth frame", lows, 0);
    chk("b2b tx_full drained", tx_full, 0);

    // reset in the middle of TX data bit 3 with a frame queued
    rx_frame(8'h77, 1'b0);
    repeat (20) @(negedge CLOCK_50);
    chk("pre-reset frame_err", frame_err, 1);
    send(8'hC3);
    send(8'h99);
    repeat (43) @(negedge CLOCK_50);
    chk("pre-reset line bit3", UART_TX, 0);
    reset = 1'b0;
    send_flag = 1'b1;
    @(negedge CLOCK_50);
    chk("mid-tx reset UART_TX", UART_TX, 1);
    chk("mid-tx reset tx_full", tx_full, 0);
    chk("mid-tx reset data_available", data_available, 0);
    chk("mid-tx reset frame_err", frame_err, 0);
    chk("mid-tx reset rx_overrun", rx_overrun, 0);
    chk("mid-tx reset out", out, 0);
    @(negedge CLOCK_50);
    reset = 1'b1;
    idle_low(300, lows);
    chk("post-reset line idle", lows, 0);
    send_flag = 1'b0;
    @(negedge CLOCK_50);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
